// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped branch target buffer with saturating direction counters
//
// Ports:
//   CLK, RST          clock and synchronous active-high reset
//   enable            pipeline advance qualifier; gates table training and mispredict counting
//   invalidate        clears every valid bit at the next edge; overrides a same-cycle update
//   lk_pc             fetch PC looked up combinationally
//   pred_hit          lk_pc matches a valid entry
//   pred_taken        hit and counter MSB set
//   pred_next         stored target when predicted taken, else lk_pc + 4
//   upd_valid         MEM stage holds a resolved branch or jump
//   upd_pc            PC of the resolved instruction
//   upd_taken         actual direction
//   upd_target        actual target address
//   upd_mispredict    fetch used the wrong next address for this instruction
//   mispredict_count  running mispredict total, wraps modulo 2^CNT_W
module branch_target_predictor #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             enable,
    input  logic             invalidate,
    input  logic [31:0]      lk_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [31:0]      pred_next,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_mispredict,
    output logic [CNT_W-1:0] mispredict_count
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];
    logic [CTR_W-1:0]   ctr_d    [ENTRIES];
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             upd_hit;
    logic             unused_upd_pc;

    assign lk_idx  = lk_pc[IDX_W+1:2];
    assign lk_tag  = lk_pc[IDX_W+1+TAG_W:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[IDX_W+1+TAG_W:IDX_W+2];
    // Byte-offset and high PC bits take no part in indexing or tagging.
    assign unused_upd_pc = ^upd_pc;

    // Lookup reads only registered state, so a same-cycle update is never bypassed.
    assign pred_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken = pred_hit && ctr_q[lk_idx][CTR_W-1];
    assign pred_next  = pred_taken ? target_q[lk_idx] : lk_pc + 32'd4;

    assign upd_hit          = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign mispredict_count = cnt_q;

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        cnt_d    = (upd_valid && upd_mispredict && enable) ? cnt_q + CNT_W'(1) : cnt_q;
        if (invalidate) begin
            valid_d = '0;
        end else if (upd_valid && enable) begin
            if (upd_hit) begin
                ctr_d[upd_idx] = upd_taken
                    ? ((ctr_q[upd_idx] == CTR_MAX) ? CTR_MAX : ctr_q[upd_idx] + CTR_W'(1))
                    : ((ctr_q[upd_idx] == '0) ? '0 : ctr_q[upd_idx] - CTR_W'(1));
                target_d[upd_idx] = upd_taken ? upd_target : target_q[upd_idx];
            end else if (upd_taken) begin
                // Only taken branches allocate; a new entry starts weakly taken.
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                ctr_d[upd_idx]    = CTR_WT;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            ctr_q   <= ctr_d;
        end
    end

    // Tags and targets need no reset value; they only matter once valid is set.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: directed scoreboard bench for branch_target_predictor
module tb_branch_target_predictor;
    typedef struct packed {
        logic [31:0] pc;
        logic        hit;
        logic        taken;
        logic [31:0] next;
        logic [31:0] cnt;
    } exp_t;

    logic        CLK = 0;
    logic        RST = 1;
    logic        enable = 1;
    logic        invalidate = 0;
    logic [31:0] lk_pc = 0;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_next;
    logic        upd_valid = 0;
    logic [31:0] upd_pc = 0;
    logic        upd_taken = 0;
    logic [31:0] upd_target = 0;
    logic        upd_mispredict = 0;
    logic [31:0] mispredict_count;

    logic        look_v = 0;
    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_cnt = 0;

    branch_target_predictor dut (
        .CLK(CLK), .RST(RST), .enable(enable), .invalidate(invalidate),
        .lk_pc(lk_pc), .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next(pred_next),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .mispredict_count(mispredict_count)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (look_v) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL lookup pc=%h: no expected entry queued", lk_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.pc !== lk_pc || pred_hit !== e.hit || pred_taken !== e.taken ||
                    pred_next !== e.next || mispredict_count !== e.cnt) begin
                    n_bad++;
                    $display("FAIL lookup pc=%h got hit=%0d taken=%0d next=%h cnt=%0d want hit=%0d taken=%0d next=%h cnt=%0d",
                             lk_pc, pred_hit, pred_taken, pred_next, mispredict_count,
                             e.hit, e.taken, e.next, e.cnt);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic mis);
        upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tg; upd_mispredict = mis;
        if (mis && enable) exp_cnt++;
        step();
        upd_valid = 0; upd_mispredict = 0;
    endtask

    task automatic look(input logic [31:0] pc, input logic hit, input logic tk, input logic [31:0] nx);
        lk_pc = pc;
        exp_q.push_back('{pc, hit, tk, nx, exp_cnt});
        look_v = 1;
        step();
        look_v = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(); step();
        RST = 0;
        look(32'h40, 0, 0, 32'h44);
        upd(32'h40, 1, 32'h100, 1);
        look(32'h40, 1, 1, 32'h100);
        upd(32'h40, 0, 32'h0, 0);
        look(32'h40, 1, 0, 32'h44);
        upd(32'h40, 0, 32'h0, 1);
        look(32'h40, 1, 0, 32'h44);
        upd(32'h40, 0, 32'h0, 0);
        upd(32'h40, 1, 32'h104, 0);
        look(32'h40, 1, 0, 32'h44);
        upd(32'h40, 1, 32'h104, 0);
        look(32'h40, 1, 1, 32'h104);
        upd(32'h40, 1, 32'h104, 0);
        upd(32'h40, 1, 32'h104, 1);
        look(32'h40, 1, 1, 32'h104);
        upd(32'h40, 0, 32'h0, 0);
        look(32'h40, 1, 1, 32'h104);
        upd(32'h40, 0, 32'h0, 0);
        look(32'h40, 1, 0, 32'h44);
        look(32'h44, 0, 0, 32'h48);
        upd(32'h440, 1, 32'h200, 0);
        look(32'h440, 1, 1, 32'h200);
        look(32'h40, 0, 0, 32'h44);
        upd_valid = 1; upd_pc = 32'h80; upd_taken = 1; upd_target = 32'h300;
        look(32'h80, 0, 0, 32'h84);
        upd_valid = 0;
        look(32'h80, 1, 1, 32'h300);
        invalidate = 1;
        upd(32'h440, 1, 32'h500, 1);
        invalidate = 0;
        look(32'h440, 0, 0, 32'h444);
        look(32'h80, 0, 0, 32'h84);
        upd(32'h80, 0, 32'h900, 0);
        look(32'h80, 0, 0, 32'h84);
        enable = 0;
        for (int i = 0; i < 3; i++) upd(32'h80, 1, 32'h600, 1);
        look(32'h80, 0, 0, 32'h84);
        enable = 1;
        look(32'h80, 0, 0, 32'h84);
        upd(32'hC0, 1, 32'h700, 0);
        look(32'hC0, 1, 1, 32'h700);
        enable = 0; invalidate = 1;
        step();
        enable = 1; invalidate = 0;
        look(32'hC0, 0, 0, 32'hC4);
        look(32'hFFFF_FFFC, 0, 0, 32'h0);
        upd(32'hFFFF_FFFC, 1, 32'h10, 1);
        look(32'hFFFF_FFFC, 1, 1, 32'h10);
        RST = 1;
        upd(32'h40, 1, 32'h100, 1);
        RST = 0;
        exp_cnt = 0;
        look(32'h40, 0, 0, 32'h44);
        look(32'hFFFF_FFFC, 0, 0, 32'h0);
        step(); step();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard drain: %0d left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
